// File: rtl/riscv_wb_ctrl.sv
// Wishbone-classic register slave bridging the host to riscv_top: drives compare_in,
// samples led_out, counts LED transitions and raises a maskable change interrupt.
module riscv_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [23:0] compare_out,
    input  logic [6:0]  led_in,
    output logic        irq_o
);

    localparam logic [1:0] REG_COMPARE = 2'd0;
    localparam logic [1:0] REG_LED     = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    logic        ack_q,      ack_d;
    logic [31:0] dat_q,      dat_d;
    logic [23:0] compare_q,  compare_d;
    logic [6:0]  led_q,      led_d;
    logic [6:0]  led_prev_q, led_prev_d;
    logic        chg_q,      chg_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic        irq_en_q,   irq_en_d;

    logic        hit;
    logic        wr_hit;
    logic [1:0]  reg_sel;
    logic        led_change;
    logic        chg_clr;
    logic [31:0] rdata;

    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

    // Blocking the hit while ack is high keeps every ack exactly one cycle wide.
    always_comb begin
        hit        = wbs_cyc_i & wbs_stb_i
                   & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
        wr_hit     = hit & wbs_we_i;
        reg_sel    = wbs_adr_i[3:2];
        led_change = (led_q != led_prev_q);
        chg_clr    = wr_hit & (reg_sel == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[0];
    end

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_COMPARE: rdata = {8'h0, compare_q};
            REG_LED:     rdata = {25'h0, led_q};
            REG_STATUS:  rdata = {16'h0, cnt_q, 7'h0, chg_q};
            REG_CTRL:    rdata = {31'h0, irq_en_q};
            default:     rdata = 32'h0;
        endcase
    end

    always_comb begin
        ack_d      = hit;
        dat_d      = hit ? rdata : dat_q;
        led_d      = led_in;
        led_prev_d = led_q;

        compare_d = compare_q;
        if (wr_hit && reg_sel == REG_COMPARE) begin
            for (int b = 0; b < 3; b++) begin
                if (wbs_sel_i[b]) begin
                    compare_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                end
            end
        end

        irq_en_d = irq_en_q;
        if (wr_hit && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
            irq_en_d = wbs_dat_i[0];
        end

        // A transition on the same edge as a clear must not be lost.
        chg_d = chg_q;
        if (led_change) begin
            chg_d = 1'b1;
        end else if (chg_clr) begin
            chg_d = 1'b0;
        end

        cnt_d = led_change ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            compare_q  <= 24'h0;
            led_q      <= 7'h0;
            led_prev_q <= 7'h0;
            chg_q      <= 1'b0;
            cnt_q      <= 8'h0;
            irq_en_q   <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            compare_q  <= compare_d;
            led_q      <= led_d;
            led_prev_q <= led_prev_d;
            chg_q      <= chg_d;
            cnt_q      <= cnt_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign compare_out = compare_q;
    assign irq_o       = chg_q & irq_en_q;

endmodule
